// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Result is packed {remainder, quotient} to match the ALU hi/lo path.
//
// state  | meaning
// S_IDLE | waiting for start
// S_DIV  | iterating, one quotient bit per clock, busy=1
// S_DONE | result valid, ready=1 for one cycle

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_signed_div,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_annul,
    output logic                 o_busy,
    output logic                 o_ready,
    output logic [2*WIDTH-1:0]   o_result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_ready;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_finish;
    logic               w_zero_div;
    logic               w_b_zero;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_b_zero = (i_b == '0);
    assign w_sign_a = i_signed_div & i_a[WIDTH-1];
    assign w_sign_b = i_signed_div & i_b[WIDTH-1];
    assign w_a_mag  = w_sign_a ? -i_a : i_a;
    assign w_b_mag  = w_sign_b ? -i_b : i_b;

    // Compare on the full partial remainder so a divisor with its MSB set cannot overflow.
    assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_ge       = ({r_rem, r_quo[WIDTH-1]} >= {2'b00, r_div});
    assign w_rem_next = w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    assign w_quo_fix = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_rem_fix = r_neg_r ? -w_rem_next[WIDTH-1:0] : w_rem_next[WIDTH-1:0];

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_zero_div   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_b_zero) begin
                        w_state_next = S_DONE;
                        w_zero_div   = 1'b1;
                    end else begin
                        w_state_next = S_DIV;
                        w_accept     = 1'b1;
                    end
                end
            end
            S_DIV: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                    w_finish     = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Annul overrides everything and leaves the result untouched.
        if (i_annul) begin
            w_state_next = S_IDLE;
            w_accept     = 1'b0;
            w_finish     = 1'b0;
            w_zero_div   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy  <= (w_state_next == S_DIV);
            r_ready <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_quo   <= w_a_mag;
                r_div   <= w_b_mag;
                r_neg_q <= w_sign_a ^ w_sign_b;
                r_neg_r <= w_sign_a;
            end else if (r_state == S_DIV) begin
                r_cnt <= r_cnt + CW'(1);
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
            end
            if (w_zero_div) begin
                r_result <= {i_a, {WIDTH{1'b1}}};
            end else if (w_finish) begin
                r_result <= {w_rem_fix, w_quo_fix};
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_ready  = r_ready;
    assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, sign handling,
// divide-by-zero, overflow, annul, reset and start handshake.

module tb_div_unit;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_signed_div;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_annul;
    logic        o_busy;
    logic        o_ready;
    logic [63:0] o_result;

    int n_pass  = 0;
    int n_total = 0;

    div_unit #(.WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_signed_div (i_signed_div),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_annul      (i_annul),
        .o_busy       (o_busy),
        .o_ready      (o_ready),
        .o_result     (o_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issues one operation, scrambles operands after the start edge, and checks
    // latency, busy duration, result, single-cycle ready and result holding.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int exp_lat, input string tag);
        int cyc;
        int nbusy;
        bit got;
        @(negedge clk);
        i_a = a; i_b = b; i_signed_div = s; i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0; i_a = ~a; i_b = 32'h5; i_signed_div = ~s;
        cyc = 0; nbusy = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (o_busy) nbusy++;
            if (o_ready) got = 1'b1;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, " busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        chk({tag, " result"}, o_result, exp);
        @(negedge clk);
        chk({tag, " ready_pulse"}, 64'(o_ready), 64'd0);
        chk({tag, " result_hold"}, o_result, exp);
    endtask

    initial begin
        int cnt_ready;
        int cnt_busy;
        bit got;
        int cyc;

        i_rst = 1'b1; i_start = 1'b0; i_signed_div = 1'b0;
        i_a = '0; i_b = '0; i_annul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy",   64'(o_busy),  64'd0);
        chk("reset ready",  64'(o_ready), 64'd0);
        chk("reset result", o_result,     64'h0);
        i_rst = 1'b0;

        run_op(32'd100,        32'd7,          1'b0, 64'h0000_0002_0000_000E, 33, "u100div7");
        run_op(32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33, "s-7div2");
        run_op(32'd7,          32'hFFFF_FFFE,  1'b1, 64'h0000_0001_FFFF_FFFD, 33, "s7div-2");
        run_op(32'hFFFF_FF9C,  32'd7,          1'b1, 64'hFFFF_FFFE_FFFF_FFF2, 33, "s-100div7");
        run_op(32'h1234_5678,  32'd0,          1'b0, 64'h1234_5678_FFFF_FFFF, 1,  "udiv0");
        run_op(32'h1234_5678,  32'd0,          1'b1, 64'h1234_5678_FFFF_FFFF, 1,  "sdiv0");
        run_op(32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 64'h7FFF_FFFE_0000_0001, 33, "umaxdiv");
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h0000_0000_8000_0000, 33, "soverflow");

        // annul at edge N+10
        @(negedge clk);
        i_a = 32'd100; i_b = 32'd7; i_signed_div = 1'b0; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (10) @(negedge clk);
        i_annul = 1'b1;
        @(negedge clk);
        i_annul = 1'b0;
        chk("annul busy",   64'(o_busy),  64'd0);
        chk("annul ready",  64'(o_ready), 64'd0);
        chk("annul result", o_result,     64'h0000_0000_8000_0000);
        cnt_ready = 0; cnt_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_ready) cnt_ready++;
            if (o_busy) cnt_busy++;
        end
        chk("annul no_ready", 64'(cnt_ready), 64'd0);
        chk("annul no_busy",  64'(cnt_busy),  64'd0);

        // reset at edge N+10
        @(negedge clk);
        i_a = 32'd100; i_b = 32'd7; i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (10) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        chk("midrst busy",   64'(o_busy),  64'd0);
        chk("midrst ready",  64'(o_ready), 64'd0);
        chk("midrst result", o_result,     64'h0);
        run_op(32'd9, 32'd3, 1'b0, 64'h0000_0000_0000_0003, 33, "u9div3");

        // start held high: one op, operand changes ignored, next op at first IDLE edge
        @(negedge clk);
        i_a = 32'd20; i_b = 32'd3; i_signed_div = 1'b0; i_start = 1'b1;
        @(posedge clk);
        #1 i_a = 32'd9; i_b = 32'd3;
        cyc = 0; cnt_ready = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (o_ready) begin
                cnt_ready++;
                got = 1'b1;
            end
        end
        chk("held latency", 64'(cyc), 64'd33);
        chk("held result",  o_result, 64'h0000_0002_0000_0006);
        @(negedge clk);
        chk("held idle busy",  64'(o_busy),  64'd0);
        chk("held idle ready", 64'(o_ready), 64'd0);
        @(negedge clk);
        chk("held restart busy", 64'(o_busy), 64'd1);
        i_start = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (o_ready) got = 1'b1;
        end
        chk("held second latency", 64'(cyc), 64'd32);
        chk("held second result",  o_result, 64'h0000_0000_0000_0003);

        // annul and start in the same IDLE cycle
        @(negedge clk);
        i_a = 32'd50; i_b = 32'd5; i_start = 1'b1; i_annul = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_annul = 1'b0;
        chk("annul_start busy", 64'(o_busy), 64'd0);
        cnt_ready = 0; cnt_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_ready) cnt_ready++;
            if (o_busy) cnt_busy++;
        end
        chk("annul_start no_ready", 64'(cnt_ready), 64'd0);
        chk("annul_start no_busy",  64'(cnt_busy),  64'd0);
        chk("annul_start result",   o_result,       64'h0000_0000_0000_0003);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the execute stage. It serves DIV and DIVU so that division no longer has to be one combinational operator inside the ALU.
- The execute stage is the initiator: it issues start with operands, stalls the pipeline while busy, and takes the result on ready.
- The 64-bit result uses the same packing as the ALU hi/lo path: {remainder, quotient}. Remainder is written to HI, quotient to LO.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, synchronous active-high reset
- start, input, 1, request a division; sampled only in IDLE
- signed_div, input, 1, 1 = DIV (signed), 0 = DIVU (unsigned); sampled with start
- a, input, 32, dividend; sampled with start
- b, input, 32, divisor; sampled with start
- annul, input, 1, cancel the operation in flight (exception or flush)
- busy, output, 1, high while in DIV state; the pipeline stalls on busy
- ready, output, 1, one-cycle pulse; result is valid from this cycle on
- result, output, 64, {remainder[31:0], quotient[31:0]}

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (rst). All outputs are registered.
- Reset: state=IDLE, busy=0, ready=0, result=0, internal counter and registers cleared.
- Reset has priority over every other input in every state, including mid-division.
- States:
  - IDLE: waiting.
  - DIV: iterating, busy=1.
  - DONE: ready=1 for exactly one cycle, then IDLE unconditionally.
- IDLE to DIV, start=1 at edge N with b!=0:
  - Latch |a| and |b| (magnitudes if signed_div, raw values otherwise), the sign of a, and sign(a) XOR sign(b).
  - Clear the counter.
- IDLE to DONE, start=1 with b==0:
  - result = {a, 32'hFFFF_FFFF}, independent of signed_div.
  - ready high in the cycle after edge N.
- DIV:
  - Radix-2 restoring algorithm, one quotient bit per edge, 32 iterations at edges N+1..N+32.
  - Partial remainder is 33 bits wide, so no overflow when the divisor MSB is set.
- End of DIV, edge N+32:
  - Apply sign fixup and write result.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - State goes to DONE: ready=1 and busy=0 during the cycle after edge N+32. State is IDLE after edge N+33.
- Overflow case: signed 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000, remainder 0. This is the natural two's-complement wrap with no trap.
- Holding: result holds its value until the next completion or reset. ready deasserting does not clear it.
- start while state != IDLE is ignored; no queuing. The initiator must hold start until it sees busy or ready.
- annul, any state, at an edge:
  - State goes to IDLE, busy=0, ready=0, result unchanged.
  - In DIV it aborts the iteration. In DONE it suppresses the ready pulse for that cycle.
  - annul and start in the same IDLE cycle: annul wins and no operation starts.
- A new start is accepted no earlier than the first IDLE cycle after DONE.
- Operand changes on a/b/signed_div after the start edge have no effect on the operation in flight.

Test Plan:
- Unsigned, reset released, start at edge N with a=100, b=7, signed_div=0:
  - busy=1 for edges N+1..N+32.
  - ready=1 only in the cycle after N+32.
  - result=64'h0000_0002_0000_000E.
- Signed, a=-7 (0xFFFF_FFF9), b=2, signed_div=1:
  - result=64'hFFFF_FFFF_FFFF_FFFD (r=-1, q=-3).
  - Repeat with a=7, b=-2: result=64'h0000_0001_FFFF_FFFD.
- Divide by zero and max divisor:
  - a=0x1234_5678, b=0, either signedness: ready the cycle after start, busy never high, result=64'h1234_5678_FFFF_FFFF.
  - Unsigned 0xFFFF_FFFF / 0x8000_0001: q=1, r=0x7FFF_FFFE.
- Signed overflow:
  - 0x8000_0000 / 0xFFFF_FFFF, signed: result=64'h0000_0000_8000_0000, latency 33 cycles.
- Annul and reset mid-operation:
  - annul at edge N+10: busy=0 next cycle, no ready pulse, result keeps its prior value.
  - rst at N+10: all outputs 0.
  - A subsequent start with 9/3 gives result=64'h0000_0000_0000_0003.
- Handshake:
  - start held high continuously through the operation: only one operation runs; start pulses during DIV/DONE are ignored.
  - The next operation begins at the first IDLE edge.
  - annul+start in the same IDLE cycle: no operation starts.
